systolic_tile_scheduler: RTL and testbench
==========================================

Name: systolic_tile_scheduler

Overview:
Sequences the systolic array controller across a tiled matrix multiply. A job covers K_TILES x N_TILES weight tiles of N_SIZE x N_SIZE. For each tile the block loads the weight tile, runs one full compute pass over all activation rows, and tells the output path whether to overwrite or accumulate. It sits between the layer-level command sequencer and the array controller, and owns load_weight/valid_in generation plus the tile addressing.

Parameters:
N_SIZE, 32, array dimension; weight-load length in cycles and tile edge
MAX_TILES, 64, maximum tiles per dimension
TW, 7, tile-count width ($clog2(MAX_TILES)+1); counts 1..MAX_TILES
WT_ADDR_WIDTH, 16, weight-buffer row address width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_k_tiles  in  TW  K-dimension tile count (reduction)
cmd_n_tiles  in  TW  N-dimension tile count (output columns)
abort  in  1  synchronous job kill
sa_ready  in  1  array controller idle
sa_done  in  1  array controller last-write pulse
sa_load_weight  out  1  to controller load_weight
sa_valid_in  out  1  to controller valid_in
wt_base_addr  out  WT_ADDR_WIDTH  first weight-buffer row of current tile
cur_k  out  TW-1  current K index
cur_n  out  TW-1  current N index
acc_en  out  1  1 = accumulate into output (cur_k != 0); 0 = overwrite
busy  out  1  job in progress
job_done  out  1  one-cycle pulse after the final tile
cmd_err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset: all outputs 0 except cmd_ready = 1; state IDLE; latched counts, indices and counters cleared.
- States: IDLE, LOAD_W, GAP, COMPUTE, ADVANCE, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch both counts.
  - If either count is 0 or exceeds MAX_TILES: pulse cmd_err on the next cycle and stay in IDLE.
  - Otherwise set cur_k = cur_n = 0 and go to LOAD_W only if sa_ready = 1. If sa_ready = 0, hold the latched command in a PEND flag and go to LOAD_W on the first cycle sa_ready = 1.
- LOAD_W:
  - sa_load_weight = 1 for exactly N_SIZE consecutive cycles, timed by a load counter 0..N_SIZE-1.
  - Then go to GAP.
- GAP:
  - Exactly 1 cycle with sa_load_weight = 0 and sa_valid_in = 0, letting the controller return to IDLE.
  - Go to COMPUTE.
- COMPUTE:
  - sa_valid_in = 1 continuously.
  - When sa_done = 1 is sampled, deassert sa_valid_in on the next cycle and go to ADVANCE.
  - sa_done outside COMPUTE is ignored.
- ADVANCE (1 cycle):
  - If cur_k < k_tiles-1: cur_k++.
  - Else if cur_n < n_tiles-1: cur_k = 0, cur_n++.
  - Else go to DONE.
  - Otherwise go to LOAD_W.
- DONE: job_done = 1 for 1 cycle, then IDLE.
- wt_base_addr = (cur_n*k_tiles + cur_k)*N_SIZE. It is registered, updated in ADVANCE and at command accept, and stable throughout LOAD_W/GAP/COMPUTE. Products are truncated to WT_ADDR_WIDTH; the job issuer guarantees no overflow.
- acc_en = (cur_k != 0). It is registered with the indices and stable for the whole tile.
- busy = 1 in every state except IDLE.
- Per-tile latency = 1 + N_SIZE + compute cycles + 1.
- abort:
  - Highest priority in every state; return to IDLE next cycle.
  - sa_load_weight and sa_valid_in drop that cycle.
  - No job_done and no cmd_err pulse.
  - Indices are cleared.
  - abort in IDLE clears PEND.
- cmd_valid while busy is ignored (cmd_ready = 0).
- Asserting rst_n low mid-job immediately forces the reset values.

Decomposition:
- Package systolic_pkg holds:
  - the sched_state_t enum (3-bit);
  - the constants N_SIZE, MAX_TILES, TW, WT_ADDR_WIDTH;
  - a tile_cmd_t struct {k_tiles, n_tiles}.
- One sub-module: tile_index_counter, a nested K/N counter with advance, clear, last flag and base-address multiply-accumulate (kept as an incremental add of N_SIZE per step, not a multiplier).

Test Plan:
1. k=1, n=1, sa_ready = 1, controller model done after 590 cycles -> sa_load_weight high exactly 32 cycles; 1-cycle gap; sa_valid_in high until done; job_done 1 cycle after ADVANCE; acc_en = 0 throughout.
2. k=3, n=2 -> tile order (k,n) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); wt_base_addr = 0,32,64,96,128,160; acc_en = 0,1,1,0,1,1; exactly one job_done.
3. cmd k=0, n=4; then k=65, n=1 -> cmd_err pulses twice, busy stays 0, no sa_* activity.
4. abort on cycle 10 of LOAD_W and separately mid-COMPUTE of tile (1,0) for a k=2, n=2 job -> next cycle IDLE, sa_* low, cmd_ready = 1, no job_done; a following k=1, n=1 job completes normally.
5. cmd accepted with sa_ready = 0 for 5 cycles -> no sa_load_weight until sa_ready rises, then a 32-cycle load; cmd_valid pulses during the job are ignored.
6. Stray sa_done during LOAD_W and GAP -> ignored; tile does not advance. Reset asserted mid-COMPUTE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic tile scheduler.
// Also holds the helper that range-checks a tile count.
package systolic_pkg;

    localparam int N_SIZE        = 32;
    localparam int MAX_TILES     = 64;
    localparam int TW            = 7;
    localparam int WT_ADDR_WIDTH = 16;
    localparam int LCW           = $clog2(N_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_GAP     = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [TW-1:0] k_tiles;
        logic [TW-1:0] n_tiles;
    } tile_cmd_t;

    // A tile count is usable when it lies in 1..MAX_TILES.
    function automatic logic count_ok(input logic [TW-1:0] cnt);
        return (cnt != 7'd0) && (cnt <= TW'(MAX_TILES));
    endfunction

endpackage

// File: rtl/systolic_tile_scheduler_if.sv
// Command and array-controller handshake bundle of the tile scheduler.
// The master modport is the scheduler side; slave is the environment side.
interface systolic_tile_scheduler_if;
    import systolic_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_k_tiles;
    logic [TW-1:0] cmd_n_tiles;
    logic          sa_ready;
    logic          sa_done;
    logic          sa_load_weight;
    logic          sa_valid_in;

    modport master (
        input  cmd_valid, cmd_k_tiles, cmd_n_tiles, sa_ready, sa_done,
        output cmd_ready, sa_load_weight, sa_valid_in
    );

    modport slave (
        output cmd_valid, cmd_k_tiles, cmd_n_tiles, sa_ready, sa_done,
        input  cmd_ready, sa_load_weight, sa_valid_in
    );

endinterface

// File: rtl/tile_index_counter.sv
// Nested K-inner / N-outer tile counter with registered base address and acc flag.
// Tiles are visited in linear order, so the base address simply grows by N_SIZE per step.
module tile_index_counter
    import systolic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     advance,
    input  logic [TW-1:0]            k_tiles,
    input  logic [TW-1:0]            n_tiles,
    output logic [TW-2:0]            cur_k,
    output logic [TW-2:0]            cur_n,
    output logic [WT_ADDR_WIDTH-1:0] base_addr,
    output logic                     acc_en,
    output logic                     last
);

    logic [TW-2:0]            cur_k_r;
    logic [TW-2:0]            cur_n_r;
    logic [WT_ADDR_WIDTH-1:0] base_r;
    logic                     acc_r;
    logic                     k_last_s;
    logic                     n_last_s;

    assign k_last_s = ({1'b0, cur_k_r} == (k_tiles - 7'd1));
    assign n_last_s = ({1'b0, cur_n_r} == (n_tiles - 7'd1));

    // Index, base-address and accumulate-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_k_r <= 6'd0;
            cur_n_r <= 6'd0;
            base_r  <= 16'd0;
            acc_r   <= 1'b0;
        end else if (clear) begin
            cur_k_r <= 6'd0;
            cur_n_r <= 6'd0;
            base_r  <= 16'd0;
            acc_r   <= 1'b0;
        end else if (advance) begin
            if (!k_last_s) begin
                cur_k_r <= cur_k_r + 6'd1;
                acc_r   <= 1'b1;
            end else begin
                cur_k_r <= 6'd0;
                acc_r   <= 1'b0;
                if (!n_last_s) begin
                    cur_n_r <= cur_n_r + 6'd1;
                end else begin
                    cur_n_r <= cur_n_r;
                end
            end
            base_r <= base_r + WT_ADDR_WIDTH'(N_SIZE);
        end else begin
            cur_k_r <= cur_k_r;
            cur_n_r <= cur_n_r;
            base_r  <= base_r;
            acc_r   <= acc_r;
        end
    end

    assign cur_k     = cur_k_r;
    assign cur_n     = cur_n_r;
    assign base_addr = base_r;
    assign acc_en    = acc_r;
    assign last      = k_last_s & n_last_s;

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Walks a K_TILES x N_TILES job: weight load, one-cycle gap, compute pass, advance.
// Outputs are registered from the next state so they line up with the state register.
module systolic_tile_scheduler
    import systolic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    systolic_tile_scheduler_if.master sch_bus,
    input  logic                     abort,
    output logic [WT_ADDR_WIDTH-1:0] wt_base_addr,
    output logic [TW-2:0]            cur_k,
    output logic [TW-2:0]            cur_n,
    output logic                     acc_en,
    output logic                     busy,
    output logic                     job_done,
    output logic                     cmd_err
);

    sched_state_t   state_r;
    sched_state_t   state_s;
    tile_cmd_t      cmd_r;
    logic           pend_r;
    logic           pend_s;
    logic [LCW-1:0] load_cnt_r;
    logic           accept_s;
    logic           cmd_ok_s;
    logic           clear_s;
    logic           advance_s;
    logic           last_s;

    logic           load_s, valid_s, busy_s, done_s, ready_s;
    logic           load_r, valid_r, busy_r, done_r, ready_r, err_r;

    assign cmd_ok_s  = count_ok(sch_bus.cmd_k_tiles) && count_ok(sch_bus.cmd_n_tiles);
    assign clear_s   = abort | (accept_s & cmd_ok_s);
    assign advance_s = (state_r == ST_ADVANCE) & ~abort & ~last_s;

    // State and pending-command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_s  = state_r;
        pend_s   = pend_r;
        accept_s = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
            pend_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_r) begin
                        if (sch_bus.sa_ready) begin
                            state_s = ST_LOAD_W;
                            pend_s  = 1'b0;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else if (sch_bus.cmd_valid) begin
                        accept_s = 1'b1;
                        if (cmd_ok_s && sch_bus.sa_ready) begin
                            state_s = ST_LOAD_W;
                        end else if (cmd_ok_s) begin
                            pend_s = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD_W: begin
                    if (load_cnt_r == LCW'(N_SIZE - 1)) begin
                        state_s = ST_GAP;
                    end else begin
                        state_s = ST_LOAD_W;
                    end
                end
                ST_GAP:     state_s = ST_COMPUTE;
                ST_COMPUTE: begin
                    if (sch_bus.sa_done) begin
                        state_s = ST_ADVANCE;
                    end else begin
                        state_s = ST_COMPUTE;
                    end
                end
                ST_ADVANCE: begin
                    if (last_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOAD_W;
                    end
                end
                ST_DONE:    state_s = ST_IDLE;
                default:    state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state.
    always_comb begin
        load_s  = (state_s == ST_LOAD_W);
        valid_s = (state_s == ST_COMPUTE);
        busy_s  = (state_s != ST_IDLE);
        done_s  = (state_s == ST_DONE);
        ready_s = (state_s == ST_IDLE) && !pend_s;
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_r  <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            load_r  <= load_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ready_r <= ready_s;
            err_r   <= accept_s & ~cmd_ok_s;
        end
    end

    // Weight-load cycle counter; sits at zero outside LOAD_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_r <= '0;
        end else if ((state_r == ST_LOAD_W) && (state_s == ST_LOAD_W)) begin
            load_cnt_r <= load_cnt_r + LCW'(1);
        end else begin
            load_cnt_r <= '0;
        end
    end

    // Command latch; counts are captured on every sampled request in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r <= '0;
        end else if (accept_s) begin
            cmd_r <= '{k_tiles: sch_bus.cmd_k_tiles, n_tiles: sch_bus.cmd_n_tiles};
        end else begin
            cmd_r <= cmd_r;
        end
    end

    tile_index_counter u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_s),
        .advance   (advance_s),
        .k_tiles   (cmd_r.k_tiles),
        .n_tiles   (cmd_r.n_tiles),
        .cur_k     (cur_k),
        .cur_n     (cur_n),
        .base_addr (wt_base_addr),
        .acc_en    (acc_en),
        .last      (last_s)
    );

    // The array strobes drop in the same cycle abort is raised.
    assign sch_bus.sa_load_weight = load_r & ~abort;
    assign sch_bus.sa_valid_in    = valid_r & ~abort;
    assign sch_bus.cmd_ready      = ready_r;
    assign busy                   = busy_r;
    assign job_done               = done_r;
    assign cmd_err                = err_r;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler with hand-computed tile sequences.
module tb_systolic_tile_scheduler;
    import systolic_pkg::*;

    logic                     clk;
    logic                     rst_n;
    logic                     abort;
    logic [WT_ADDR_WIDTH-1:0] wt_base_addr;
    logic [TW-2:0]            cur_k;
    logic [TW-2:0]            cur_n;
    logic                     acc_en;
    logic                     busy;
    logic                     job_done;
    logic                     cmd_err;

    int n_checks;
    int n_errors;

    systolic_tile_scheduler_if sif ();

    systolic_tile_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sch_bus      (sif),
        .abort        (abort),
        .wt_base_addr (wt_base_addr),
        .cur_k        (cur_k),
        .cur_n        (cur_n),
        .acc_en       (acc_en),
        .busy         (busy),
        .job_done     (job_done),
        .cmd_err      (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int k, input int n);
        sif.cmd_valid   = 1'b1;
        sif.cmd_k_tiles = TW'(k);
        sif.cmd_n_tiles = TW'(n);
        tick();
        sif.cmd_valid   = 1'b0;
    endtask

    // Entered on the first LOAD_W cycle; leaves one cycle after ADVANCE.
    task automatic run_tile(input int ek, input int en, input int eb, input int ea,
                            input int comp_len, input bit stray, input bit noise);
        int lcnt;
        int vcnt;
        bit moved;
        lcnt  = 0;
        vcnt  = 0;
        moved = 1'b0;
        check_eq("tile_k", cur_k, ek);
        check_eq("tile_n", cur_n, en);
        check_eq("tile_base", wt_base_addr, eb);
        check_eq("tile_acc", acc_en, ea);
        if (noise) begin
            sif.cmd_valid   = 1'b1;
            sif.cmd_k_tiles = 7'd2;
            sif.cmd_n_tiles = 7'd2;
        end
        while (sif.sa_load_weight && lcnt < 100) begin
            if (int'(cur_k) != ek || int'(cur_n) != en || int'(wt_base_addr) != eb) moved = 1'b1;
            sif.sa_done = stray && (lcnt == 5);
            tick();
            lcnt++;
        end
        check_eq("load_len", lcnt, 32);
        check_eq("gap_valid", sif.sa_valid_in, 0);
        sif.sa_done = stray;
        tick();
        sif.sa_done   = 1'b0;
        sif.cmd_valid = 1'b0;
        for (int i = 0; i < comp_len; i++) begin
            if (sif.sa_valid_in) vcnt++;
            if (int'(cur_k) != ek || int'(cur_n) != en || int'(acc_en) != ea) moved = 1'b1;
            sif.sa_done = (i == comp_len - 1);
            tick();
        end
        sif.sa_done = 1'b0;
        check_eq("comp_len", vcnt, comp_len);
        check_eq("adv_valid", sif.sa_valid_in, 0);
        check_eq("tile_stable", moved, 0);
        tick();
    endtask

    initial begin
        int ks[6];
        int ns[6];
        int errs;
        ks = '{0, 1, 2, 0, 1, 2};
        ns = '{0, 0, 0, 1, 1, 1};
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        abort           = 1'b0;
        sif.cmd_valid   = 1'b0;
        sif.cmd_k_tiles = 7'd0;
        sif.cmd_n_tiles = 7'd0;
        sif.sa_ready    = 1'b1;
        sif.sa_done     = 1'b0;
        repeat (3) tick();
        check_eq("rst_ready", sif.cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_load", sif.sa_load_weight, 0);
        check_eq("rst_base", wt_base_addr, 0);
        rst_n = 1'b1;
        tick();

        // 1: single tile, long compute pass
        send_cmd(1, 1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_ready", sif.cmd_ready, 0);
        run_tile(0, 0, 0, 0, 590, 1'b0, 1'b0);
        check_eq("t1_done", job_done, 1);
        tick();
        check_eq("t1_done_end", job_done, 0);
        check_eq("t1_idle", busy, 0);
        check_eq("t1_ready_end", sif.cmd_ready, 1);

        // 2: 3x2 job walks K inside N
        send_cmd(3, 2);
        for (int t = 0; t < 6; t++) begin
            run_tile(ks[t], ns[t], 32 * t, (ks[t] != 0) ? 1 : 0, 8, 1'b0, 1'b0);
            check_eq("t2_done", job_done, (t == 5) ? 1 : 0);
        end
        tick();
        check_eq("t2_done_end", job_done, 0);
        check_eq("t2_idle", busy, 0);

        // 3: illegal counts are rejected
        errs = 0;
        send_cmd(0, 4);
        if (cmd_err) errs++;
        check_eq("t3_busy_a", busy, 0);
        check_eq("t3_load_a", sif.sa_load_weight, 0);
        tick();
        check_eq("t3_err_pulse", cmd_err, 0);
        send_cmd(65, 1);
        if (cmd_err) errs++;
        check_eq("t3_busy_b", busy, 0);
        tick();
        check_eq("t3_err_count", errs, 2);
        check_eq("t3_load_b", sif.sa_load_weight, 0);

        // 4a: abort on load cycle 10
        send_cmd(2, 2);
        repeat (10) tick();
        check_eq("t4_pre_load", sif.sa_load_weight, 1);
        abort = 1'b1;
        #1;
        check_eq("t4_load_drop", sif.sa_load_weight, 0);
        tick();
        abort = 1'b0;
        check_eq("t4_busy", busy, 0);
        check_eq("t4_ready", sif.cmd_ready, 1);
        tick();
        check_eq("t4_no_done", job_done, 0);

        // 4b: abort mid-compute of tile (1,0)
        send_cmd(2, 2);
        run_tile(0, 0, 0, 0, 10, 1'b0, 1'b0);
        repeat (33) tick();
        check_eq("t4_comp_k", cur_k, 1);
        check_eq("t4_comp_valid", sif.sa_valid_in, 1);
        repeat (3) tick();
        abort = 1'b1;
        #1;
        check_eq("t4_valid_drop", sif.sa_valid_in, 0);
        tick();
        abort = 1'b0;
        check_eq("t4b_busy", busy, 0);
        check_eq("t4b_k_clr", cur_k, 0);
        check_eq("t4b_acc_clr", acc_en, 0);
        check_eq("t4b_ready", sif.cmd_ready, 1);
        check_eq("t4b_no_done", job_done, 0);
        send_cmd(1, 1);
        run_tile(0, 0, 0, 0, 6, 1'b0, 1'b0);
        check_eq("t4_after_done", job_done, 1);
        tick();

        // 5: accepted while the array is busy, command noise during the job
        sif.sa_ready = 1'b0;
        send_cmd(1, 1);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (sif.sa_load_weight) errs++;
            tick();
        end
        if (sif.sa_load_weight) errs++;
        check_eq("t5_no_load", errs, 0);
        sif.sa_ready = 1'b1;
        tick();
        check_eq("t5_load_start", sif.sa_load_weight, 1);
        run_tile(0, 0, 0, 0, 12, 1'b0, 1'b1);
        check_eq("t5_done", job_done, 1);
        check_eq("t5_no_err", cmd_err, 0);
        tick();
        check_eq("t5_idle", busy, 0);

        // 6: stray sa_done in LOAD_W/GAP, then reset mid-compute
        send_cmd(2, 1);
        run_tile(0, 0, 0, 0, 9, 1'b1, 1'b0);
        check_eq("t6_next_k", cur_k, 1);
        check_eq("t6_next_base", wt_base_addr, 32);
        repeat (34) tick();
        check_eq("t6_comp_valid", sif.sa_valid_in, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", sif.sa_valid_in, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_ready", sif.cmd_ready, 1);
        check_eq("t6_rst_base", wt_base_addr, 0);
        check_eq("t6_rst_k", cur_k, 0);
        check_eq("t6_rst_acc", acc_en, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
